channel_sim_sequencer: RTL

//  Run controller for the Tx channel-simulation datapath (symbol source -> symbol_to_signal -> ISI_channel).
//  Per run: loads PULSE_RESPONSE_LENGTH pulse-response taps from a host stream into the channel tap registers,

---
 rtl/serdes_sim_pkg.sv | 24 ++
 rtl/seq_down_timer.sv | 35 +++
 rtl/channel_sim_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/serdes_sim_pkg.sv
// Shared definitions for the Tx channel-simulation blocks: sequencer state
// encoding, datapath defaults and a constant-safe clog2 helper.
package serdes_sim_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  localparam int SIGNAL_RESOLUTION = 8;
  localparam int SYMBOL_SEPERATION = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/seq_down_timer.sv
// Loadable down-counter that stops at zero; zero_o reflects the registered count.
module seq_down_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/channel_sim_sequencer.sv
// Run controller for the channel-simulation datapath: loads channel taps,
// paces symbol strobes, then drains returned samples with a timeout.
module channel_sim_sequencer
  import serdes_sim_pkg::*;
#(
  parameter int  PULSE_RESPONSE_LENGTH = 2,
  parameter int  TAP_WIDTH             = 8,
  parameter int  COUNT_WIDTH           = 16,
  parameter int  DRAIN_TIMEOUT         = 64,
  localparam int AW = (clog2(PULSE_RESPONSE_LENGTH) < 1) ? 1 : clog2(PULSE_RESPONSE_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] num_symbols,
  input  logic [7:0]             gap_cycles,
  input  logic [TAP_WIDTH-1:0]   tap_in_data,
  input  logic                   tap_in_valid,
  output logic                   tap_in_ready,
  output logic                   tap_wr_en,
  output logic [AW-1:0]          tap_wr_addr,
  output logic [TAP_WIDTH-1:0]   tap_wr_data,
  output logic                   sym_valid,
  input  logic                   chan_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] symbols_sent,
  output logic [COUNT_WIDTH-1:0] samples_received,
  output logic                   err_timeout
);

  localparam int            DTW      = clog2(DRAIN_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_TAP = AW'(PULSE_RESPONSE_LENGTH - 1);

  seq_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] num_sym_q, num_sym_d;
  logic [7:0]             gap_q, gap_d;
  logic [AW-1:0]          tap_idx_q, tap_idx_d;
  logic [COUNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
  logic [COUNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
  logic                   err_q, err_d;
  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [TAP_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   ready_q, ready_d;
  logic                   sym_valid_q, sym_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic gap_load, gap_dec, gap_zero;
  logic drain_load, drain_dec, drain_zero;
  logic tap_xfer;

  seq_down_timer #(.W(8)) u_gap_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (gap_load),
    .load_val_i (gap_q - 8'd1),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  seq_down_timer #(.W(DTW)) u_drain_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (drain_load),
    .load_val_i (DTW'(DRAIN_TIMEOUT - 1)),
    .dec_i      (drain_dec),
    .zero_o     (drain_zero)
  );

  always_comb begin
    state_d    = state_q;
    num_sym_d  = num_sym_q;
    gap_d      = gap_q;
    tap_idx_d  = tap_idx_q;
    sym_cnt_d  = sym_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    tap_xfer   = tap_in_valid && ready_q;

    // Returned samples only belong to the run while it is active.
    if ((state_q inside {LOAD, RUN, GAP, DRAIN}) && chan_valid && (smp_cnt_q != '1)) begin
      smp_cnt_d = smp_cnt_q + COUNT_WIDTH'(1);
    end
    if (state_q == RUN) begin
      sym_cnt_d = sym_cnt_q + COUNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          num_sym_d = num_symbols;
          gap_d     = gap_cycles;
          sym_cnt_d = '0;
          smp_cnt_d = '0;
          err_d     = 1'b0;
          tap_idx_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (tap_xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tap_idx_q;
          wr_data_d = tap_in_data;
          tap_idx_d = tap_idx_q + AW'(1);
          if (tap_idx_q == LAST_TAP) begin
            if (num_sym_q == '0) begin
              state_d    = DRAIN;
              drain_load = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      RUN: begin
        if (sym_cnt_d == num_sym_q) begin
          state_d    = DRAIN;
          drain_load = 1'b1;
        end else if (gap_q == 8'd0) begin
          state_d = RUN;
        end else begin
          state_d  = GAP;
          gap_load = 1'b1;
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d = RUN;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DRAIN: begin
        if (smp_cnt_q >= sym_cnt_q) begin
          state_d = DONE;
        end else if (drain_zero) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          drain_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
    end

    // Strobe outputs are registered copies of what the next state implies.
    ready_d     = (state_d == LOAD);
    sym_valid_d = (state_d == RUN);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      num_sym_q   <= '0;
      gap_q       <= '0;
      tap_idx_q   <= '0;
      sym_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_sym_q   <= num_sym_d;
      gap_q       <= gap_d;
      tap_idx_q   <= tap_idx_d;
      sym_cnt_q   <= sym_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= ready_d;
      sym_valid_q <= sym_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tap_in_ready     = ready_q;
  assign tap_wr_en        = wr_en_q;
  assign tap_wr_addr      = wr_addr_q;
  assign tap_wr_data      = wr_data_q;
  assign sym_valid        = sym_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign symbols_sent     = sym_cnt_q;
  assign samples_received = smp_cnt_q;
  assign err_timeout      = err_q;

endmodule
